// File: rtl/uart_rx_sampler.sv
// UART receive front end: rx synchroniser, 16x oversampling tick generator and
// start/data/stop deframer that strobes each byte into the downstream rx FIFO.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line idle, waiting for rx_s low (start edge)
//   START | counting to mid start bit, re-checking the line there
//   DATA  | sampling DBIT data bits at mid-bit, LSB first
//   STOP  | counting through the stop bit, sampling at its end tick
//   BRK   | line stuck low after a bad stop bit; wait for it to go high
module uart_rx_sampler #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx,
    output logic [DBIT-1:0]   dout,
    output logic              rx_done_tick,
    output logic              frame_err,
    output logic              busy
);

    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_LAST = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [DVSR_W-1:0] c;
    logic              tick;
    logic [S_W-1:0]    s;
    logic [N_W-1:0]    n;
    logic [DBIT-1:0]   b;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // >= rather than == so a divisor lowered below the current count fires at once
    assign tick = (c >= dvsr);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            c <= '0;
        end else if (tick) begin
            c <= '0;
        end else begin
            c <= c + 1'b1;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        s     <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                s     <= '0;
                                n     <= '0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            s            <= '0;
                            dout         <= b;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                            state        <= rx_s ? IDLE : BRK;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
